fp_to_int_converter: RTL



---
 rtl/fp_to_int_converter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fp_to_int_converter.sv
// Iterative converter from the 32-bit custom float (bias 511, 10b exp, 21b frac) to signed int32.
// Optional ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation toward zero.
module fp_to_int_converter #(
  parameter int BIAS   = 511,
  parameter int FRAC_W = 21,
  parameter int EXP_W  = 10
) (
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic        start_in,
  input  logic [31:0] fp_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] int_out,
  output logic [3:0]  status_out
);

  typedef enum logic [2:0] {IDLE, DECODE, SHIFT, SIGN, WRITEBACK} state_t;
  typedef enum logic [3:0] {
    OVERFLOW  = 4'd0,
    UNDERFLOW = 4'd1,
    EXACT     = 4'd2,
    INEXACT   = 4'd3
  } status_t;

  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] FRAC_S = EW'(FRAC_W);
  localparam logic signed [EW-1:0] E_OVF  = EW'(31);
`ifdef ROUND_NEAREST_EN
  localparam logic signed [EW-1:0] E_MIN  = EW'(-1);
`else
  localparam logic signed [EW-1:0] E_MIN  = EW'(0);
`endif

  state_t            state;
  status_t           res_st;
  status_t           status_q;
  logic [31:0]       fp_q;
  logic [31:0]       acc;
  logic [31:0]       mag;
  logic              sticky;
  logic [4:0]        n_q;
  logic              dir_left;
`ifdef ROUND_NEAREST_EN
  logic              guard;
`endif

  logic [EXP_W-1:0]  exp_f;
  logic signed [EW-1:0] e_unb;
  logic signed [EW-1:0] diff;
  logic [4:0]        n_w;

  assign status_out = status_q;

  always_comb begin
    exp_f = fp_q[FRAC_W +: EXP_W];
    e_unb = $signed({2'b00, exp_f}) - BIAS_S;
    diff  = e_unb - FRAC_S;
    n_w   = 5'((diff < 0) ? -diff : diff);
  end

  // Magnitude before negation; rounding increments here so negation sees the final value.
  always_comb begin
    mag = acc;
`ifdef ROUND_NEAREST_EN
    mag = acc + {31'b0, guard & (sticky | acc[0])};
`endif
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fp_q     <= '0;
      acc      <= '0;
      sticky   <= 1'b0;
      n_q      <= '0;
      dir_left <= 1'b0;
      res_st   <= EXACT;
      status_q <= EXACT;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      int_out  <= '0;
`ifdef ROUND_NEAREST_EN
      guard    <= 1'b0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            fp_q     <= fp_in;
            busy_out <= 1'b1;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (exp_f == '0) begin
            acc    <= '0;
            res_st <= (fp_q[30:0] == '0) ? EXACT : UNDERFLOW;
            state  <= WRITEBACK;
          end else if (e_unb < E_MIN) begin
            acc    <= '0;
            res_st <= UNDERFLOW;
            state  <= WRITEBACK;
          end else if (e_unb >= E_OVF) begin
            acc    <= fp_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            res_st <= OVERFLOW;
            state  <= WRITEBACK;
          end else begin
            acc      <= 32'({1'b1, fp_q[FRAC_W-1:0]});
            sticky   <= 1'b0;
`ifdef ROUND_NEAREST_EN
            guard    <= 1'b0;
`endif
            n_q      <= n_w;
            dir_left <= (diff >= 0);
            state    <= (n_w != '0) ? SHIFT : SIGN;
          end
        end
        SHIFT: begin
          if (dir_left) begin
            acc <= acc << 1;
          end else begin
            acc <= acc >> 1;
`ifdef ROUND_NEAREST_EN
            guard  <= acc[0];
            sticky <= sticky | guard;
`else
            sticky <= sticky | acc[0];
`endif
          end
          n_q <= n_q - 5'd1;
          if (n_q == 5'd1) state <= SIGN;
        end
        SIGN: begin
          acc <= fp_q[31] ? -mag : mag;
`ifdef ROUND_NEAREST_EN
          if (mag == '0)            res_st <= UNDERFLOW;
          else if (guard | sticky)  res_st <= INEXACT;
          else                      res_st <= EXACT;
`else
          res_st <= sticky ? INEXACT : EXACT;
`endif
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          int_out  <= acc;
          status_q <= res_st;
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
